// File: rtl/axis_ascon_aead128_tag_gate_if.sv
`default_nettype none
// ============================================================================
//  Module   : axis_ascon_aead128_tag_gate_if
//  Purpose  : AXI-Stream bundle used by the Ascon tag gate for its plaintext
//             input, tag input, released plaintext output and status output.
//  Signals  : tvalid, tready, tlast, tdata[DW-1:0], tkeep[KW-1:0]
//  Modports : master (drives tvalid/tlast/tdata/tkeep, samples tready)
//             slave  (samples tvalid/tlast/tdata/tkeep, drives tready)
//  Revision : 1.0  initial release
// ============================================================================
interface axis_ascon_aead128_tag_gate_if #(
    parameter int DW = 128,
    parameter int KW = 16
);
    logic          tvalid;
    logic          tready;
    logic          tlast;
    logic [DW-1:0] tdata;
    logic [KW-1:0] tkeep;

    modport master (output tvalid, tlast, tdata, tkeep, input tready);
    modport slave  (input tvalid, tlast, tdata, tkeep, output tready);
endinterface
`default_nettype wire

// File: rtl/axis_ascon_aead128_tag_gate.sv
`default_nettype none
// ============================================================================
//  Module   : axis_ascon_aead128_tag_gate
//  Purpose  : Buffers one decrypted Ascon-AEAD128 plaintext frame and releases
//             it only when the core's tag comparison result is all-zero.
//             One status word {overflow, auth_fail} is emitted per frame.
//  Ports    : clk, resetn (synchronous, active-low)
//             s        : plaintext in      (128b data, 16b keep, tlast)
//             s_tag    : tag result in     (128b, all-zero = pass)
//             m        : released plaintext out
//             m_status : status out (tdata[0]=auth_fail, tdata[1]=overflow),
//                        instantiate its interface with DW=2, KW=1
//  Params   : AW           log2 of buffer depth in beats
//             KEEP_SUPPORT 0 = tkeep not stored, m.tkeep driven all-ones
//  Option   : ASCON_TAG_GATE_ZEROIZE_EN - failed (non-overflow) frames are
//             drained with tdata forced to zero instead of being dropped.
//  Revision : 1.0  initial release
// ============================================================================
module axis_ascon_aead128_tag_gate #(
    parameter int AW           = 4,
    parameter bit KEEP_SUPPORT = 1'b1
) (
    input  wire logic                       clk,
    input  wire logic                       resetn,
    axis_ascon_aead128_tag_gate_if.slave    s,
    axis_ascon_aead128_tag_gate_if.slave    s_tag,
    axis_ascon_aead128_tag_gate_if.master   m,
    axis_ascon_aead128_tag_gate_if.master   m_status
);

    localparam int          DEPTH     = 1 << AW;
    localparam logic [AW:0] c_depth   = (AW+1)'(DEPTH);
    localparam logic [AW:0] c_ptr_one = (AW+1)'(1);

`ifdef ASCON_TAG_GATE_ZEROIZE_EN
    localparam bit c_zeroize = 1'b1;
`else
    localparam bit c_zeroize = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_FILL     = 3'd0,
        ST_DISCARD  = 3'd1,
        ST_WAIT_TAG = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_DROP     = 3'd4,
        ST_STATUS   = 3'd5
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    logic [AW:0]    r_wr_ptr;
    logic [AW:0]    r_rd_ptr;
    logic           r_ovf;
    logic           r_fail;
    logic [1:0]     r_status;

    logic           r_m_tvalid;
    logic           r_m_tlast;
    logic [127:0]   r_m_tdata;
    logic [15:0]    r_m_tkeep;

    logic [127:0]   r_mem_data [DEPTH];
    logic [15:0]    w_rd_keep;
    logic           w_keep_unused;

    logic           w_s_tready;
    logic           w_tag_tready;
    logic           w_status_tvalid;
    logic           w_s_acc;
    logic           w_tag_acc;
    logic           w_m_acc;
    logic           w_st_acc;
    logic           w_fail;
    logic           w_full;
    logic           w_wr_en;
    logic           w_drain_go;
    logic           w_load;
    logic           w_last_rd;
    logic           w_zero;

    // ------------------------------------------------------------------
    // Handshake and datapath decode
    // ------------------------------------------------------------------
    assign w_s_acc   = s.tvalid && w_s_tready;
    assign w_tag_acc = s_tag.tvalid && w_tag_tready;
    assign w_m_acc   = r_m_tvalid && m.tready;
    assign w_st_acc  = w_status_tvalid && m_status.tready;
    assign w_fail    = |s_tag.tdata;
    assign w_full    = (r_wr_ptr - r_rd_ptr) == c_depth;

    // A beat arriving on a full buffer is swallowed and marks the frame as
    // overflowed; it is never written.
    assign w_wr_en   = w_s_acc && (r_state == ST_FILL) && !w_full;

    // Frames with overflow are always dropped; failed frames are drained only
    // in zeroize builds so downstream framing stays aligned.
    assign w_drain_go = !r_ovf && (!w_fail || c_zeroize);

    // The first beat is loaded on the tag handshake itself so m.tvalid rises
    // one cycle later; subsequent beats load on each output handshake, giving
    // a bubble-free 1 beat/clk drain.
    assign w_load    = (w_tag_acc && w_drain_go) ||
                       ((r_state == ST_DRAIN) && w_m_acc && !r_m_tlast);
    assign w_last_rd = (r_rd_ptr + c_ptr_one) == r_wr_ptr;
    assign w_zero    = (r_state == ST_WAIT_TAG) ? w_fail : r_fail;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and handshake outputs (depend on state only, so
    // there is no combinational path from m.tready to s.tready)
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_s_tready      = 1'b0;
        w_tag_tready    = 1'b0;
        w_status_tvalid = 1'b0;
        case (r_state)
            ST_FILL: begin
                w_s_tready = 1'b1;
                if (s.tvalid && s.tlast) begin
                    w_state_nxt = ST_WAIT_TAG;
                end else if (s.tvalid && w_full) begin
                    w_state_nxt = ST_DISCARD;
                end
            end
            ST_DISCARD: begin
                w_s_tready = 1'b1;
                if (s.tvalid && s.tlast) begin
                    w_state_nxt = ST_WAIT_TAG;
                end
            end
            ST_WAIT_TAG: begin
                w_tag_tready = 1'b1;
                if (s_tag.tvalid) begin
                    w_state_nxt = w_drain_go ? ST_DRAIN : ST_DROP;
                end
            end
            ST_DRAIN: begin
                if (w_m_acc && r_m_tlast) begin
                    w_state_nxt = ST_STATUS;
                end
            end
            ST_DROP: begin
                w_state_nxt = ST_STATUS;
            end
            ST_STATUS: begin
                w_status_tvalid = 1'b1;
                if (m_status.tready) begin
                    w_state_nxt = ST_FILL;
                end
            end
            default: begin
                w_state_nxt = ST_FILL;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pointers, flags, status and output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_ovf      <= 1'b0;
            r_fail     <= 1'b0;
            r_status   <= 2'b00;
            r_m_tvalid <= 1'b0;
            r_m_tlast  <= 1'b0;
            r_m_tdata  <= '0;
            r_m_tkeep  <= '0;
        end else begin
            case (r_state)
                ST_FILL: begin
                    if (w_s_acc) begin
                        if (w_full) begin
                            r_ovf <= 1'b1;
                        end else begin
                            r_wr_ptr <= r_wr_ptr + c_ptr_one;
                        end
                    end
                end
                ST_WAIT_TAG: begin
                    if (w_tag_acc) begin
                        r_fail <= w_fail;
                    end
                end
                ST_DRAIN: begin
                    if (w_m_acc && r_m_tlast) begin
                        r_status <= {1'b0, r_fail};
                    end
                end
                ST_DROP: begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                    r_status <= {r_ovf, r_fail};
                end
                ST_STATUS: begin
                    if (w_st_acc) begin
                        r_ovf    <= 1'b0;
                        r_fail   <= 1'b0;
                        r_wr_ptr <= '0;
                        r_rd_ptr <= '0;
                    end
                end
                default: begin
                end
            endcase

            if (w_load) begin
                r_m_tvalid <= 1'b1;
                r_m_tdata  <= w_zero ? '0 : r_mem_data[r_rd_ptr[AW-1:0]];
                r_m_tkeep  <= w_rd_keep;
                r_m_tlast  <= w_last_rd;
                r_rd_ptr   <= r_rd_ptr + c_ptr_one;
            end else if (w_m_acc) begin
                r_m_tvalid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame buffer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem_data[r_wr_ptr[AW-1:0]] <= s.tdata;
        end
    end

    generate
        if (KEEP_SUPPORT) begin : g_keep
            logic [15:0] r_mem_keep [DEPTH];
            always_ff @(posedge clk) begin
                if (w_wr_en) begin
                    r_mem_keep[r_wr_ptr[AW-1:0]] <= s.tkeep;
                end
            end
            assign w_rd_keep     = r_mem_keep[r_rd_ptr[AW-1:0]];
            assign w_keep_unused = 1'b0;
        end else begin : g_no_keep
            assign w_rd_keep     = '1;
            assign w_keep_unused = ^s.tkeep;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Output drive
    // ------------------------------------------------------------------
    assign s.tready        = w_s_tready;
    assign s_tag.tready    = w_tag_tready;

    assign m.tvalid        = r_m_tvalid;
    assign m.tdata         = r_m_tdata;
    assign m.tkeep         = r_m_tkeep;
    assign m.tlast         = r_m_tlast;

    assign m_status.tvalid = w_status_tvalid;
    assign m_status.tdata  = r_status;
    assign m_status.tlast  = 1'b1;
    assign m_status.tkeep  = '1;

    // Tag stream carries a single word; its framing fields are not needed.
    wire w_unused = &{1'b0, s_tag.tlast, s_tag.tkeep, w_keep_unused};

endmodule
`default_nettype wire

// File: tb/tb_axis_ascon_aead128_tag_gate.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axis_ascon_aead128_tag_gate
//  Purpose  : Self-checking bench for axis_ascon_aead128_tag_gate (AW=2).
//             Expected beats/status are queued as frames are sent and
//             compared when the DUT emits them.
//  Revision : 1.0  initial release
// ============================================================================
module tb_axis_ascon_aead128_tag_gate;

    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;
`ifdef ASCON_TAG_GATE_ZEROIZE_EN
    localparam bit ZEROIZE = 1'b1;
`else
    localparam bit ZEROIZE = 1'b0;
`endif

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    axis_ascon_aead128_tag_gate_if #(.DW(128), .KW(16)) s_if ();
    axis_ascon_aead128_tag_gate_if #(.DW(128), .KW(16)) tag_if ();
    axis_ascon_aead128_tag_gate_if #(.DW(128), .KW(16)) m_if ();
    axis_ascon_aead128_tag_gate_if #(.DW(2),   .KW(1))  st_if ();

    axis_ascon_aead128_tag_gate #(.AW(AW), .KEEP_SUPPORT(1'b1)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .s        (s_if),
        .s_tag    (tag_if),
        .m        (m_if),
        .m_status (st_if)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [159:0] exp_q [$];
    logic [1:0]   st_q  [$];

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Output monitor / scoreboard (samples on the falling edge)
    // ------------------------------------------------------------------
    logic         hold_m  = 1'b0;
    logic [159:0] prev_m  = '0;
    logic         hold_st = 1'b0;
    logic [1:0]   prev_st = '0;

    always @(negedge clk) begin
        logic [159:0] obs;
        if (!resetn) begin
            hold_m  = 1'b0;
            hold_st = 1'b0;
        end else begin
            obs = {15'd0, m_if.tdata, m_if.tkeep, m_if.tlast};
            if (hold_m) begin
                check("m_valid_held", m_if.tvalid, 1'b1);
                check("m_data_stable", obs, prev_m);
            end
            if (m_if.tvalid && m_if.tready) begin
                check("m_beat_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) check("m_beat", obs, exp_q.pop_front());
            end
            hold_m = m_if.tvalid && !m_if.tready;
            prev_m = obs;

            if (hold_st) begin
                check("st_valid_held", st_if.tvalid, 1'b1);
                check("st_data_stable", st_if.tdata, prev_st);
            end
            if (st_if.tvalid && st_if.tready) begin
                check("status_expected", st_q.size() > 0, 1'b1);
                if (st_q.size() > 0) check("status", st_if.tdata, st_q.pop_front());
            end
            hold_st = st_if.tvalid && !st_if.tready;
            prev_st = st_if.tdata;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic send_beat(input logic [127:0] d, input logic [15:0] k, input logic l,
                             output int waited);
        waited = 0;
        s_if.tvalid = 1'b1;
        s_if.tdata  = d;
        s_if.tkeep  = k;
        s_if.tlast  = l;
        @(negedge clk);
        while (!s_if.tready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("s_beat_accepted", waited < 50, 1'b1);
        @(posedge clk); #1;
        s_if.tvalid = 1'b0;
    endtask

    task automatic send_tag(input logic [127:0] t);
        int waited = 0;
        tag_if.tvalid = 1'b1;
        tag_if.tdata  = t;
        @(negedge clk);
        while (!tag_if.tready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("tag_accepted", waited < 50, 1'b1);
        @(posedge clk); #1;
        tag_if.tvalid = 1'b0;
    endtask

    // Frame of n beats, data byte 0x11*(i+1), last keep 0xFFF0.
    task automatic run_frame(input int n, input logic [127:0] tag);
        bit           ovf;
        bit           fail;
        bit           drains;
        int           waited;
        logic [7:0]   b;
        logic [127:0] d;
        logic [15:0]  k;
        ovf    = (n > DEPTH);
        fail   = (tag != 128'd0);
        drains = !ovf && (!fail || ZEROIZE);
        check("tag_blocked_in_fill", tag_if.tready, 1'b0);
        for (int i = 0; i < n; i++) begin
            b = 8'(8'h11 * (i + 1));
            d = {16{b}};
            k = (i == n - 1) ? 16'hFFF0 : 16'hFFFF;
            if (drains) exp_q.push_back({15'd0, (fail ? 128'd0 : d), k, (i == n - 1)});
            send_beat(d, k, (i == n - 1), waited);
            if (ovf) check("ovf_no_stall", waited, 0);
        end
        st_q.push_back({ovf, fail});
        send_tag(tag);
        check("first_valid_after_tag", m_if.tvalid, drains);
    endtask

    task automatic wait_idle();
        int c = 0;
        while ((exp_q.size() != 0 || st_q.size() != 0) && c < 200) begin
            @(posedge clk);
            c++;
        end
        #1;
        check("scoreboard_drained", exp_q.size() + st_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        int c;
        resetn         = 1'b0;
        s_if.tvalid    = 1'b0;  s_if.tdata   = '0; s_if.tkeep  = '0; s_if.tlast = 1'b0;
        tag_if.tvalid  = 1'b0;  tag_if.tdata = '0; tag_if.tkeep = '0; tag_if.tlast = 1'b0;
        m_if.tready    = 1'b1;
        st_if.tready   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_tready",  s_if.tready,   1'b1);
        check("rst_tag_tready", tag_if.tready, 1'b0);
        check("rst_m_tvalid",  m_if.tvalid,   1'b0);
        check("rst_st_tvalid", st_if.tvalid,  1'b0);
        check("rst_st_tdata",  st_if.tdata,   2'b00);
        resetn = 1'b1;
        @(posedge clk); #1;

        // Pass frame, auth fail frame
        run_frame(3, 128'd0);
        wait_idle();
        run_frame(3, 128'd1);
        wait_idle();

        // Overflow (6 beats into depth 4), then a normal single-beat frame
        run_frame(6, 128'd0);
        wait_idle();
        run_frame(1, 128'd0);
        wait_idle();

        // Exactly full frame is not an overflow
        run_frame(4, 128'd0);
        wait_idle();

        // Backpressure on data and status
        st_if.tready = 1'b0;
        run_frame(2, 128'd0);
        m_if.tready = 1'b1; @(posedge clk); #1;
        m_if.tready = 1'b0; @(posedge clk); #1;
        m_if.tready = 1'b0; @(posedge clk); #1;
        m_if.tready = 1'b1; @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            check("bp_s_tready_low", s_if.tready, 1'b0);
            check("bp_status_valid", st_if.tvalid, 1'b1);
            @(posedge clk); #1;
        end
        st_if.tready = 1'b1;
        @(posedge clk); #1;
        check("bp_s_tready_rearm", s_if.tready, 1'b1);
        wait_idle();

        // Reset in the middle of a drain
        run_frame(3, 128'd0);
        c = 0;
        while (exp_q.size() != 2 && c < 50) begin
            @(posedge clk);
            c++;
        end
        check("mid_drain_beat1_seen", exp_q.size(), 2);
        #1;
        resetn      = 1'b0;
        m_if.tready = 1'b0;
        exp_q.delete();
        st_q.delete();
        @(posedge clk); #1;
        resetn      = 1'b1;
        m_if.tready = 1'b1;
        @(posedge clk); #1;
        check("post_rst_m_tvalid",  m_if.tvalid,   1'b0);
        check("post_rst_st_tvalid", st_if.tvalid,  1'b0);
        check("post_rst_tag_tready", tag_if.tready, 1'b0);
        check("post_rst_s_tready",  s_if.tready,   1'b1);
        run_frame(2, 128'd0);
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
